intersection_sensor: RTL and testbench

Vehicle-detection front end for the two-road signalised intersection. It debounces raw loop-detector levels, keeps a waiting-vehicle count per road and generates the `S1`/`S2` service requests consumed by the traffic-light controller. It watches the controller's `light1`/`light2` outputs to retire vehicles and to flag illegal light combinations. It sits between the road-side detector pins and the light controller.

---
 rtl/intersection_sensor_if.sv | 27 ++
 rtl/intersection_sensor.sv | 115 +++++++++++
 tb/tb_intersection_sensor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/intersection_sensor_if.sv
// Detector/controller bundle for intersection_sensor: road-side inputs and light codes in,
// service requests, queue counts and error flag out.
interface intersection_sensor_if #(
  parameter int CNT_W = 4
) ();
  logic             arr1;
  logic             arr2;
  logic             dep1;
  logic             dep2;
  logic [2:0]       light1;
  logic [2:0]       light2;
  logic             S1;
  logic             S2;
  logic [CNT_W-1:0] q1;
  logic [CNT_W-1:0] q2;
  logic             err;

  modport master (
    output arr1, arr2, dep1, dep2, light1, light2,
    input  S1, S2, q1, q2, err
  );

  modport slave (
    input  arr1, arr2, dep1, dep2, light1, light2,
    output S1, S2, q1, q2, err
  );
endinterface

// File: rtl/intersection_sensor.sv
// Two-road vehicle detection front end: debounces arrivals, tracks waiting counts,
// raises S1/S2 service requests and a sticky protocol-error flag.
module intersection_sensor #(
  parameter int CNT_W = 4,
  parameter int DEB   = 3
) (
  input logic                 clk,
  input logic                 rst,
  intersection_sensor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RISE, HELD} deb_state_t;

  localparam logic [CNT_W-1:0] Q_MAX = '1;
  localparam logic [3:0]       DEB_C = 4'(DEB);
  localparam logic [2:0]       RED   = 3'b100;
  localparam logic [2:0]       YEL   = 3'b010;
  localparam logic [2:0]       GRN   = 3'b001;
  localparam logic [2:0]       DARK  = 3'b000;

  deb_state_t       state [2];
  logic [3:0]       cnt   [2];
  logic [CNT_W-1:0] q     [2];
  logic             s_req [2];
  logic             err_q;

  logic             arr       [2];
  logic             dep       [2];
  logic [2:0]       light     [2];
  logic             qual      [2];
  logic             dep_ok    [2];
  logic             dep_bad   [2];
  logic             underflow [2];
  logic             light_bad [2];
  logic             err_set;

  always_comb begin
    arr[0]   = bus.arr1;
    arr[1]   = bus.arr2;
    dep[0]   = bus.dep1;
    dep[1]   = bus.dep2;
    light[0] = bus.light1;
    light[1] = bus.light2;
    err_set  = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      // Qualification is decided on the same edge that samples the DEB-th high level.
      qual[i]      = arr[i] && (((state[i] == IDLE) && (DEB_C == 4'd1)) ||
                                ((state[i] == RISE) && ((cnt[i] + 4'd1) == DEB_C)));
      dep_ok[i]    = dep[i] && ((light[i] == GRN) || (light[i] == YEL));
      dep_bad[i]   = dep[i] && ((light[i] == RED) || (light[i] == DARK));
      underflow[i] = dep_ok[i] && !qual[i] && (q[i] == '0);
      light_bad[i] = !((light[i] == RED) || (light[i] == YEL) ||
                       (light[i] == GRN) || (light[i] == DARK));
      err_set      = err_set || dep_bad[i] || underflow[i] || light_bad[i];
    end
    err_set = err_set || ((light[0] == GRN) && (light[1] == GRN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        q[i]     <= '0;
        s_req[i] <= 1'b0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        case (state[i])
          IDLE: begin
            if (arr[i]) begin
              state[i] <= qual[i] ? HELD : RISE;
              cnt[i]   <= qual[i] ? 4'd0 : 4'd1;
            end
          end
          RISE: begin
            if (!arr[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (qual[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end
          HELD: begin
            if (!arr[i]) state[i] <= IDLE;
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase

        if (qual[i] && !dep_ok[i]) begin
          if (q[i] != Q_MAX) q[i] <= q[i] + 1'b1;
        end else if (dep_ok[i] && !qual[i]) begin
          if (q[i] != '0) q[i] <= q[i] - 1'b1;
        end

        s_req[i] <= (q[i] != '0) && (light[i] == RED);
      end
      err_q <= err_q | err_set;
    end
  end

  assign bus.S1  = s_req[0];
  assign bus.S2  = s_req[1];
  assign bus.q1  = q[0];
  assign bus.q2  = q[1];
  assign bus.err = err_q;

endmodule

// File: tb/tb_intersection_sensor.sv
// Directed bench for intersection_sensor: a CNT_W=4 instance for most traffic and a
// CNT_W=2 instance for saturation.
module tb_intersection_sensor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  intersection_sensor_if #(.CNT_W(4)) a ();
  intersection_sensor_if #(.CNT_W(2)) b ();

  intersection_sensor #(.CNT_W(4), .DEB(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  intersection_sensor #(.CNT_W(2), .DEB(3)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = a road 1, 1 = a road 2, 2 = b road 1; three high samples then one low
  task automatic arrive(input int sel);
    for (int i = 0; i < 4; i++) begin
      case (sel)
        0:       a.arr1 = (i < 3);
        1:       a.arr2 = (i < 3);
        default: b.arr1 = (i < 3);
      endcase
      step();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    a.arr1 = 0; a.arr2 = 0; a.dep1 = 0; a.dep2 = 0; a.light1 = 3'b000; a.light2 = 3'b000;
    b.arr1 = 0; b.arr2 = 0; b.dep1 = 0; b.dep2 = 0; b.light1 = 3'b000; b.light2 = 3'b000;
    #12;
    chk("reset_S1", a.S1, 0);
    chk("reset_S2", a.S2, 0);
    chk("reset_q1", a.q1, 0);
    chk("reset_q2", a.q2, 0);
    chk("reset_err", a.err, 0);
    step();
    rst = 1'b0;

    // Both lights dark is the legal startup state.
    repeat (10) step();
    chk("dark_err", a.err, 0);

    // Debounce: 2-cycle glitch ignored, then a held level counts once.
    a.light1 = 3'b100; a.light2 = 3'b100;
    a.arr1 = 1; step(); step();
    a.arr1 = 0; step();
    chk("glitch_q1", a.q1, 0);
    a.arr1 = 1; step(); step();
    chk("deb2_q1", a.q1, 0);
    step();
    chk("deb3_q1", a.q1, 1);
    chk("deb3_S1", a.S1, 0);
    step();
    chk("deb_S1", a.S1, 1);
    step(); step();
    chk("held_q1", a.q1, 1);
    a.arr1 = 0; step();

    // Illegal departure on red: count kept, err sticky.
    arrive(0);
    chk("two_q1", a.q1, 2);
    a.dep1 = 1; step();
    a.dep1 = 0;
    chk("baddep_q1", a.q1, 2);
    chk("baddep_err", a.err, 1);
    a.light1 = 3'b001; step();
    chk("green_S1", a.S1, 0);
    a.dep1 = 1; step();
    a.dep1 = 0;
    chk("legal_q1", a.q1, 1);
    chk("sticky_err", a.err, 1);

    // Asynchronous reset mid-RISE on road 2.
    a.light1 = 3'b100;
    a.arr2 = 1; step(); step();
    rst = 1'b1;
    #1;
    chk("arst_q1", a.q1, 0);
    chk("arst_err", a.err, 0);
    chk("arst_S1", a.S1, 0);
    chk("arst_q2", a.q2, 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("rearm2_q2", a.q2, 0);
    step();
    chk("rearm3_q2", a.q2, 1);
    a.arr2 = 0; step();

    // Request lifecycle on road 2.
    arrive(1);
    arrive(1);
    chk("life_q2", a.q2, 3);
    chk("life_S2", a.S2, 1);
    a.light2 = 3'b001; step();
    chk("life_S2_drop", a.S2, 0);
    chk("life_q2_kept", a.q2, 3);
    a.dep2 = 1; step();
    chk("dep_q2_2", a.q2, 2);
    step();
    chk("dep_q2_1", a.q2, 1);
    step();
    chk("dep_q2_0", a.q2, 0);
    a.dep2 = 0;
    chk("life_err", a.err, 0);

    // Both green.
    a.light1 = 3'b001; a.light2 = 3'b001; step();
    a.light2 = 3'b100;
    chk("bothgreen_err", a.err, 1);
    pulse_reset();
    chk("clr_err", a.err, 0);

    // Undefined light code.
    a.light1 = 3'b110; step();
    a.light1 = 3'b100;
    chk("badcode_err", a.err, 1);
    pulse_reset();

    // Saturation on the 2-bit instance.
    b.light1 = 3'b100;
    repeat (4) arrive(2);
    chk("sat4_q1", b.q1, 3);
    arrive(2);
    chk("sat5_q1", b.q1, 3);
    b.light1 = 3'b001;
    b.arr1 = 1; step(); step();
    b.dep1 = 1; step();
    b.dep1 = 0; b.arr1 = 0;
    chk("simul_q1", b.q1, 3);
    chk("simul_err", b.err, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
